// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Byte-level command engine behind an SPI peripheral. The first byte of each
//   chip-select frame is a header: bit7 = RW (1 read, 0 write), low ADDR_W bits =
//   start address. Write frames turn every following byte into a register write.
//   Read frames fetch a register and hand it to the peripheral. Each later byte
//   is a dummy that triggers the next fetch. At frame end the peripheral is
//   reloaded with IDLE_BYTE.
//
//   Build option: define SPI_REG_BRIDGE_AUTOINC_EN to advance the address after
//   each write byte and each streaming-read dummy byte. When it is not defined,
//   the address holds for the whole frame, so every access goes to one register
//   in the style of a FIFO port.
//
// Ports
//   i_clk, i_rst_n           clock, async active-low reset
//   i_rxDataValid, i_rxData  received byte pulse from the SPI peripheral
//   o_txDataValid, o_txData  load pulse / byte for the peripheral tx register
//   i_spiCsN                 raw SPI chip select (async, synchronised here)
//   o_rdEn, o_wrEn, o_addr   register bus strobes and address
//   o_wrData, i_rdData       register bus write/read data (read data 1 cycle after o_rdEn)
//   o_overrun                sticky: byte arrived while a read fetch was pending
//
// state      | meaning
// S_IDLE     | outside a frame, waiting for chip-select falling edge
// S_CMD      | frame open, waiting for header byte
// S_WR_DATA  | every rx byte becomes a register write
// S_RD_FETCH | o_rdEn asserted for the current address
// S_RD_LOAD  | i_rdData passed straight to the peripheral with o_txDataValid
// S_RD_WAIT  | waiting for the dummy byte that triggers the next fetch

module spi_reg_bridge #(
   parameter int         ADDR_W    = 7,
   parameter logic [7:0] IDLE_BYTE = 8'hA5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rxDataValid,
   input  logic [7:0]        i_rxData,
   output logic              o_txDataValid,
   output logic [7:0]        o_txData,
   input  logic              i_spiCsN,
   output logic              o_rdEn,
   output logic              o_wrEn,
   output logic [ADDR_W-1:0] o_addr,
   output logic [7:0]        o_wrData,
   input  logic [7:0]        i_rdData,
   output logic              o_overrun
);

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] ADDR_STEP = '0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WR_DATA,
      S_RD_FETCH,
      S_RD_LOAD,
      S_RD_WAIT
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_cs_meta;
   logic              r_cs_sync;
   logic              r_cs_prev;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wr_en;
   logic [7:0]        r_wr_data;
   logic [7:0]        r_tx_data;
   logic              r_idle_pend;
   logic              r_idle_vld;
   logic              r_overrun;

   logic w_cs_fall;
   logic w_cs_rise;
   logic w_addr_load;
   logic w_addr_step;
   logic w_wr_fire;
   logic w_ovr_set;
   logic w_ovr_clr;

   assign w_cs_fall = r_cs_prev & ~r_cs_sync;
   assign w_cs_rise = ~r_cs_prev & r_cs_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cs_meta <= 1'b1;
         r_cs_sync <= 1'b1;
         r_cs_prev <= 1'b1;
      end else begin
         r_cs_meta <= i_spiCsN;
         r_cs_sync <= r_cs_meta;
         r_cs_prev <= r_cs_sync;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame end overrides everything. A byte that arrives in the same cycle is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_load = 1'b0;
      w_addr_step = 1'b0;
      w_wr_fire   = 1'b0;
      w_ovr_set   = 1'b0;
      w_ovr_clr   = 1'b0;
      if (w_cs_rise) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cs_fall) begin
                  w_state_nxt = S_CMD;
                  w_ovr_clr   = 1'b1;
               end
            end
            S_CMD: begin
               if (i_rxDataValid) begin
                  w_addr_load = 1'b1;
                  w_state_nxt = i_rxData[7] ? S_RD_FETCH : S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               w_wr_fire = i_rxDataValid;
            end
            S_RD_FETCH: begin
               w_ovr_set   = i_rxDataValid;
               w_state_nxt = S_RD_LOAD;
            end
            S_RD_LOAD: begin
               w_ovr_set   = i_rxDataValid;
               w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (i_rxDataValid) begin
                  w_addr_step = 1'b1;
                  w_state_nxt = S_RD_FETCH;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // The write address advances in the cycle after the write strobe. This keeps
   // o_addr valid alongside o_wrEn.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr      <= '0;
         r_wr_en     <= 1'b0;
         r_wr_data   <= 8'h00;
         r_tx_data   <= IDLE_BYTE;
         r_idle_pend <= 1'b0;
         r_idle_vld  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_wr_en <= w_wr_fire;
         if (w_wr_fire) begin
            r_wr_data <= i_rxData;
         end
         if (w_addr_load) begin
            r_addr <= i_rxData[ADDR_W-1:0];
         end else if (w_addr_step || r_wr_en) begin
            r_addr <= r_addr + ADDR_STEP;
         end
         if (w_cs_rise) begin
            r_tx_data <= IDLE_BYTE;
         end else if (r_state == S_RD_LOAD) begin
            r_tx_data <= i_rdData;
         end
         // The idle byte sits on o_txData for a cycle before its load pulse.
         r_idle_pend <= w_cs_rise;
         r_idle_vld  <= r_idle_pend;
         if (w_ovr_clr) begin
            r_overrun <= 1'b0;
         end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
         end
      end
   end

   // Read data is forwarded combinationally to meet the two-cycle header-to-load latency.
   assign o_rdEn        = (r_state == S_RD_FETCH);
   assign o_txDataValid = r_idle_vld | (r_state == S_RD_LOAD);
   assign o_txData      = (r_state == S_RD_LOAD) ? i_rdData : r_tx_data;
   assign o_wrEn        = r_wr_en;
   assign o_wrData      = r_wr_data;
   assign o_addr        = r_addr;
   assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;
   localparam int         ADDR_W    = 7;
   localparam logic [7:0] IDLE_BYTE = 8'hA5;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   localparam int INC = 1;
`else
   localparam int INC = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_vld = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       cs_n = 1'b1;
   logic [7:0] rd_data = 8'hEE;
   logic       tx_vld;
   logic [7:0] tx_data;
   logic       rd_en;
   logic       wr_en;
   logic [6:0] addr;
   logic [7:0] wr_data;
   logic       overrun;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_reg_bridge #(.ADDR_W(ADDR_W), .IDLE_BYTE(IDLE_BYTE)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rxDataValid(rx_vld), .i_rxData(rx_data),
      .o_txDataValid(tx_vld), .o_txData(tx_data),
      .i_spiCsN(cs_n),
      .o_rdEn(rd_en), .o_wrEn(wr_en), .o_addr(addr),
      .o_wrData(wr_data), .i_rdData(rd_data),
      .o_overrun(overrun)
   );

   typedef struct {logic [6:0] a; logic [7:0] d;} wr_t;
   wr_t        wr_q[$],  exp_wr_q[$];
   logic [6:0] rd_q[$],  exp_rd_q[$];
   logic [7:0] tx_q[$],  exp_tx_q[$];

   // Register bus slave: returns address x 2 one cycle after the read strobe.
   logic [6:0] rd_cap;
   always @(negedge clk) begin
      if (rst_n && rd_en) begin
         rd_cap = addr;
         @(posedge clk); #1;
         rd_data = {rd_cap, 1'b0};
         @(posedge clk); #1;
         rd_data = 8'hEE;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en)  wr_q.push_back(wr_t'{a: addr, d: wr_data});
         if (rd_en)  rd_q.push_back(addr);
         if (tx_vld) tx_q.push_back(tx_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_vld = 1'b1; rx_data = b;
      cyc(1);
      rx_vld = 1'b0;
      cyc(7);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      cyc(4);
   endtask

   task automatic cs_high();
      cs_n = 1'b1;
      cyc(6);
   endtask

   task automatic clear_all();
      wr_q.delete(); rd_q.delete(); tx_q.delete();
      exp_wr_q.delete(); exp_rd_q.delete(); exp_tx_q.delete();
   endtask

   task automatic compare_frame(input string tag);
      check({tag, " wr count"}, 32'(wr_q.size()), 32'(exp_wr_q.size()));
      for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++) begin
         check($sformatf("%s wr%0d addr", tag, i), 32'(wr_q[i].a), 32'(exp_wr_q[i].a));
         check($sformatf("%s wr%0d data", tag, i), 32'(wr_q[i].d), 32'(exp_wr_q[i].d));
      end
      check({tag, " rd count"}, 32'(rd_q.size()), 32'(exp_rd_q.size()));
      for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++)
         check($sformatf("%s rd%0d addr", tag, i), 32'(rd_q[i]), 32'(exp_rd_q[i]));
      check({tag, " tx count"}, 32'(tx_q.size()), 32'(exp_tx_q.size()));
      for (int i = 0; i < tx_q.size() && i < exp_tx_q.size(); i++)
         check($sformatf("%s tx%0d data", tag, i), 32'(tx_q[i]), 32'(exp_tx_q[i]));
      clear_all();
   endtask

   task automatic run_frame(input logic [7:0] hdr, input int n, input logic [7:0] d[4]);
      cs_low();
      send(hdr);
      for (int k = 0; k < n; k++) send(d[k]);
      cs_high();
   endtask

   // Reference: k-th access of a frame goes to (start + k*INC) mod 2**ADDR_W.
   task automatic model_frame(input logic [7:0] hdr, input int n, input logic [7:0] d[4]);
      int a0;
      int a;
      a0 = int'(hdr[6:0]);
      if (hdr[7]) begin
         for (int k = 0; k <= n; k++) begin
            a = (a0 + k * INC) % 128;
            exp_rd_q.push_back(7'(a));
            exp_tx_q.push_back(8'((a * 2) % 256));
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            a = (a0 + k * INC) % 128;
            exp_wr_q.push_back(wr_t'{a: 7'(a), d: d[k]});
         end
      end
      exp_tx_q.push_back(IDLE_BYTE);
   endtask

   typedef struct {
      logic [7:0] hdr;
      int         n;
      logic [7:0] d[4];
      logic [6:0] ea[3];
      logic [7:0] ev[3];
   } vec_t;
   localparam int NV = 5;
   vec_t tbl[NV];

   initial begin
      logic [7:0] dd[4];
      logic [7:0] hdr;
      int         n;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
      tbl[0] = '{hdr: 8'h05, n: 2, d: '{8'h11, 8'h22, 8'h00, 8'h00}, ea: '{7'h05, 7'h06, 7'h00}, ev: '{8'h11, 8'h22, 8'h00}};
      tbl[1] = '{hdr: 8'h7F, n: 2, d: '{8'hAA, 8'hBB, 8'h00, 8'h00}, ea: '{7'h7F, 7'h00, 7'h00}, ev: '{8'hAA, 8'hBB, 8'h00}};
      tbl[2] = '{hdr: 8'h83, n: 2, d: '{8'h00, 8'hFF, 8'h00, 8'h00}, ea: '{7'h03, 7'h04, 7'h05}, ev: '{8'h06, 8'h08, 8'h0A}};
      tbl[3] = '{hdr: 8'hFF, n: 1, d: '{8'h3C, 8'h00, 8'h00, 8'h00}, ea: '{7'h7F, 7'h00, 7'h00}, ev: '{8'hFE, 8'h00, 8'h00}};
`else
      tbl[0] = '{hdr: 8'h05, n: 2, d: '{8'h11, 8'h22, 8'h00, 8'h00}, ea: '{7'h05, 7'h05, 7'h00}, ev: '{8'h11, 8'h22, 8'h00}};
      tbl[1] = '{hdr: 8'h7F, n: 2, d: '{8'hAA, 8'hBB, 8'h00, 8'h00}, ea: '{7'h7F, 7'h7F, 7'h00}, ev: '{8'hAA, 8'hBB, 8'h00}};
      tbl[2] = '{hdr: 8'h83, n: 2, d: '{8'h00, 8'hFF, 8'h00, 8'h00}, ea: '{7'h03, 7'h03, 7'h03}, ev: '{8'h06, 8'h06, 8'h06}};
      tbl[3] = '{hdr: 8'hFF, n: 1, d: '{8'h3C, 8'h00, 8'h00, 8'h00}, ea: '{7'h7F, 7'h7F, 7'h00}, ev: '{8'hFE, 8'hFE, 8'h00}};
`endif
      tbl[4] = '{hdr: 8'h40, n: 1, d: '{8'h5C, 8'h00, 8'h00, 8'h00}, ea: '{7'h40, 7'h00, 7'h00}, ev: '{8'h5C, 8'h00, 8'h00}};

      // Reset state
      cyc(2);
      @(negedge clk);
      check("reset wrEn", 32'(wr_en), 32'd0);
      check("reset rdEn", 32'(rd_en), 32'd0);
      check("reset txValid", 32'(tx_vld), 32'd0);
      check("reset txData", 32'(tx_data), 32'(IDLE_BYTE));
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset addr", 32'(addr), 32'd0);
      cyc(1);
      rst_n = 1'b1;
      cyc(3);

      // Directed vectors
      for (int i = 0; i < NV; i++) begin
         clear_all();
         if (tbl[i].hdr[7]) begin
            for (int k = 0; k <= tbl[i].n; k++) begin
               exp_rd_q.push_back(tbl[i].ea[k]);
               exp_tx_q.push_back(tbl[i].ev[k]);
            end
         end else begin
            for (int k = 0; k < tbl[i].n; k++)
               exp_wr_q.push_back(wr_t'{a: tbl[i].ea[k], d: tbl[i].ev[k]});
         end
         exp_tx_q.push_back(IDLE_BYTE);
         run_frame(tbl[i].hdr, tbl[i].n, tbl[i].d);
         compare_frame($sformatf("vec%0d", i));
      end

      // Overrun: a byte one cycle after the read header is dropped and sticks the flag
      clear_all();
      cs_low();
      rx_vld = 1'b1; rx_data = 8'h83;
      cyc(1);
      rx_data = 8'h00;
      cyc(1);
      rx_vld = 1'b0;
      cyc(8);
      check("overrun set", 32'(overrun), 32'd1);
      cs_high();
      check("overrun held past cs high", 32'(overrun), 32'd1);
      exp_rd_q.push_back(7'h03);
      exp_tx_q.push_back(8'h06);
      exp_tx_q.push_back(IDLE_BYTE);
      compare_frame("overrun");
      cs_low();
      check("overrun cleared at frame start", 32'(overrun), 32'd0);
      cs_high();
      clear_all();

      // Frame end coincident with a write data byte
      cs_low();
      send(8'h05);
      send(8'h11);
      cs_n = 1'b1;
      cyc(2);
      rx_vld = 1'b1; rx_data = 8'h33;
      cyc(1);
      rx_vld = 1'b0;
      cyc(6);
      exp_wr_q.push_back(wr_t'{a: 7'h05, d: 8'h11});
      exp_tx_q.push_back(IDLE_BYTE);
      compare_frame("cs_vs_rx");

      // Reset mid-frame with overrun set and a read byte on o_txData
      cs_low();
      rx_vld = 1'b1; rx_data = 8'h83;
      cyc(1);
      rx_data = 8'h5A;
      cyc(1);
      rx_vld = 1'b0;
      cyc(8);
      check("pre-reset overrun", 32'(overrun), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset wrEn", 32'(wr_en), 32'd0);
      check("midreset rdEn", 32'(rd_en), 32'd0);
      check("midreset txValid", 32'(tx_vld), 32'd0);
      check("midreset txData", 32'(tx_data), 32'(IDLE_BYTE));
      check("midreset overrun", 32'(overrun), 32'd0);
      cyc(1);
      cs_n = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      clear_all();
      send(8'h12);
      send(8'h34);
      compare_frame("rx_outside_frame");

      // Random frames against the reference model
      for (int f = 0; f < 30; f++) begin
         hdr = 8'($urandom);
         n   = int'($urandom_range(1, 3));
         for (int k = 0; k < 4; k++) dd[k] = 8'($urandom);
         clear_all();
         model_frame(hdr, n, dd);
         run_frame(hdr, n, dd);
         compare_frame($sformatf("rand%0d", f));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
